// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: FSM states, instruction classes, opcode/op codes and register-select constants
package alu_seq_pkg;
  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_WR_IMM = 3'd5,
    S_WR_REG = 3'd6
`ifdef ALU_SEQ_TRAP_EN
    , S_TRAP = 3'd7
`endif
  } state_t;
  typedef enum logic [1:0] {CLS_MOVI, CLS_MOVR, CLS_ALU, CLS_CMP} cls_t;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;
  localparam logic [1:0] SEL_RN = 2'b00;
  localparam logic [1:0] SEL_RD = 2'b01;
  localparam logic [1:0] SEL_RM = 2'b10;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational IR decode into legality, instruction class and sign-extended imm8
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input  logic [DATA_W-1:0] i_ir,
  output logic              o_legal,
  output cls_t              o_cls,
  output logic [DATA_W-1:0] o_sximm8
);
  logic [2:0] w_opc;
  logic [1:0] w_op;
  assign w_opc = i_ir[DATA_W-1:DATA_W-3];
  assign w_op  = i_ir[DATA_W-4:DATA_W-5];
  // MOV has only two legal op codes; every ALU op code is legal
  assign o_legal = (w_opc == OPC_MOV) ? (w_op == OP_ADD || w_op == OP_AND) : (w_opc == OPC_ALU);
  assign o_cls = (w_opc == OPC_MOV) ? ((w_op == OP_AND) ? CLS_MOVI : CLS_MOVR) :
                 (w_op == OP_SUB) ? CLS_CMP : CLS_ALU;
  assign o_sximm8 = {{(DATA_W-IMM_W){i_ir[IMM_W-1]}}, i_ir[IMM_W-1:0]};
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle Moore sequencer for the RF/ALU datapath
// ALU_SEQ_TRAP_EN: illegal encodings lock into TRAP and raise err until reset
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s,
  input  logic              load,
  input  logic [DATA_W-1:0] instr,
  output logic              w,
  output logic [1:0]        rf_sel,
  output logic              rf_write,
  output logic              wb_sel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic [1:0]        alu_op,
  output logic [1:0]        shift,
`ifdef ALU_SEQ_TRAP_EN
  output logic              err,
`endif
  output logic [DATA_W-1:0] sximm8
);
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_ir;
  logic              w_legal;
  cls_t              w_cls;
  logic [1:0]        w_op;
  alu_seq_decode #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_dec (
    .i_ir     (r_ir),
    .o_legal  (w_legal),
    .o_cls    (w_cls),
    .o_sximm8 (sximm8)
  );
  assign w_op = r_ir[DATA_W-4:DATA_W-5];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (load && r_state == S_WAIT) r_ir <= instr;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:   w_next = s ? S_DECODE : S_WAIT;
`ifdef ALU_SEQ_TRAP_EN
      S_DECODE: w_next = !w_legal ? S_TRAP :
`else
      S_DECODE: w_next = !w_legal ? S_WAIT :
`endif
                         (w_cls == CLS_MOVI) ? S_WR_IMM :
                         (w_cls == CLS_MOVR || (w_cls == CLS_ALU && w_op == OP_NOT)) ? S_GET_B : S_GET_A;
      S_GET_A:  w_next = S_GET_B;
      S_GET_B:  w_next = S_EXEC;
      S_EXEC:   w_next = (w_cls == CLS_CMP) ? S_WAIT : S_WR_REG;
      S_WR_IMM: w_next = S_WAIT;
      S_WR_REG: w_next = S_WAIT;
`ifdef ALU_SEQ_TRAP_EN
      default:  w_next = S_TRAP;
`else
      default:  w_next = S_WAIT;
`endif
    endcase
  end
  assign w        = r_state == S_WAIT;
  assign loada    = r_state == S_GET_A;
  assign loadb    = r_state == S_GET_B;
  assign loadc    = r_state == S_EXEC;
  assign loads    = loadc && w_cls == CLS_CMP;
  assign asel     = loadc && w_cls == CLS_MOVR;
  assign alu_op   = (loadc && w_cls != CLS_MOVR) ? w_op : OP_ADD;
  assign shift    = loadc ? r_ir[4:3] : 2'b00;
  assign rf_write = r_state == S_WR_IMM || r_state == S_WR_REG;
  assign wb_sel   = r_state == S_WR_IMM;
  assign rf_sel   = loadb ? SEL_RM : (r_state == S_WR_REG) ? SEL_RD : SEL_RN;
`ifdef ALU_SEQ_TRAP_EN
  assign err      = r_state == S_TRAP;
`endif
endmodule
